dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024; data storage depth in 32-bit words, power of two, at least 4.
REQ-002 SHALL have parameter LATENCY, default 2; cycles from request acceptance to rsp_valid, legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  MEM-stage request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  store byte enables; bit i selects byte lane i.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  MEM stage accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  access error flag, qualified by rsp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP, with exactly one outstanding transaction.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on the edge where req_valid and req_ready are both 1.
REQ-017 SHALL, on acceptance, commit a store using word index req_addr[log2(DEPTH_WORDS)+1:2], writing only the enabled lanes, and SHALL capture load data into a response register in the same edge.
REQ-018 SHALL move IDLE->RESP on acceptance if LATENCY==1; otherwise IDLE->WAIT, loading a down-counter with LATENCY-1.
REQ-019 SHALL decrement the counter in WAIT and move WAIT->RESP when the counter is 1, so rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-021 SHALL NOT accept a new request in the cycle the response is consumed; the next acceptance is earliest one cycle later.
REQ-022 SHALL treat a store with req_be=0 as a successful no-op with rsp_err=0.
REQ-023 SHALL drive rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.

Reset
REQ-024 SHALL, while reset=0, force the FSM to IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and req_ready=0; req_ready returns to 1 on the first edge after reset is released.
REQ-025 SHALL discard any transaction in WAIT or RESP when reset asserts mid-operation; a store already committed at acceptance stays committed.
REQ-026 SHALL NOT reset storage contents.

Configuration
REQ-027 SHALL, when DMEM_ERR_CHECK_EN is defined, flag rsp_err=1 if req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS; the errored access SHALL suppress the store and return rsp_rdata=0 with unchanged latency.
REQ-028 SHALL, when DMEM_ERR_CHECK_EN is undefined, ignore req_addr[1:0], wrap addresses modulo DEPTH_WORDS, and tie rsp_err to 0.

Structure
REQ-029 SHALL place the dmem_req_t and dmem_rsp_t structs and the state enum in pipeline_pkg.
REQ-030 SHALL instantiate one sub-module, dmem_array, as the byte-enabled synchronous word storage; the FSM, counter and error logic stay in dmem_responder.

Verification
REQ-031 SHALL cover LATENCY=2: store 0xDEADBEEF to 0x10 with be=1111, then load 0x10 -> rsp_valid 2 cycles after each acceptance, load returns 0xDEADBEEF, rsp_err=0.
REQ-032 SHALL cover partial store: after REQ-031, store 0x000000AA to 0x10 with be=0001, then load -> load returns 0xDEADBEAA.
REQ-033 SHALL cover backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable, req_ready=0, and the next request is accepted one cycle after rsp_ready=1.
REQ-034 SHALL cover DMEM_ERR_CHECK_EN: load from 0x13 and store to 4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0, storage unchanged; without the macro, a load from 0x13 returns the word at 0x10.
REQ-035 SHALL cover reset mid-WAIT with LATENCY=4: assert reset 2 cycles after acceptance -> rsp_valid stays 0 and req_ready=1 on the first edge after release.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the MEM-stage data-memory responder: request/response
// structs, FSM state encoding and the address-error helper.
package pipeline_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

    // Misaligned, or word index beyond a 2**aw-word array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 32'd2)) != '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled synchronous word storage; read data is registered on every
// enabled access and held until the next one. Contents are never reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// Define DMEM_ERR_CHECK_EN to flag misaligned / out-of-range accesses.
module dmem_responder
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             pass_q, pass_d;

    dmem_req_t   req;
    dmem_rsp_t   rsp;
    logic        accept;
    logic        req_err;
    logic [31:0] arr_rdata;

    assign req    = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
    assign accept = req_valid & ready_q;

`ifdef DMEM_ERR_CHECK_EN
    assign req_err = addr_err(req.addr, AW);
`else
    assign req_err = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req.addr[1:0], req.addr[31:AW+2]};
`endif

    // Errored stores never reach the array; load data is captured at acceptance.
    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk_i  (clk),
        .en_i   (accept),
        .we_i   (req.we & ~req_err),
        .be_i   (req.be),
        .addr_i (req.addr[AW+1:2]),
        .wdata_i(req.wdata),
        .rdata_o(arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d  = req_err;
                    pass_d = ~req.we & ~req_err;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    // Response fields read as zero outside RESP.
    assign rsp.rdata = (valid_q && pass_q) ? arr_rdata : '0;
    assign rsp.err   = valid_q & err_q;

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rsp.rdata;
    assign rsp_err   = rsp.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=2 main instance, LATENCY=4
// instance for mid-WAIT reset); expectations follow DMEM_ERR_CHECK_EN.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam int unsigned LAT4  = 4;
`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        rst4_n = 1'b1;
    logic        r4_valid = 1'b0, r4_we = 1'b0, rsp4_ready = 1'b1;
    logic [31:0] r4_addr = '0, r4_wdata = '0;
    logic [3:0]  r4_be = '0;
    logic        req_ready4, rsp_valid4, rsp_err4;
    logic [31:0] rsp_rdata4;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT4)) u_dut4 (
        .clk(clk), .reset(rst4_n),
        .req_valid(r4_valid), .req_ready(req_ready4), .req_we(r4_we),
        .req_addr(r4_addr), .req_wdata(r4_wdata), .req_be(r4_be),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp4_ready),
        .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned acc;
        int unsigned hold;
        bit          b2b;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_issued = 0;
    bit          in_rsp   = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard on each new response and drives rsp_ready.
    initial begin
        exp_t        cur;
        int unsigned hold_left = 0;
        int unsigned last_cons = 0;
        logic [31:0] held_rd = '0;
        logic        held_err = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h, want no response (cycle %0d)",
                                 rsp_rdata, cyc);
                        hold_left = 0;
                    end else begin
                        cur = sb_q.pop_front();
                        chk("latency", cyc - cur.acc + 1, 32'(LAT));
                        chk("rdata", rsp_rdata, cur.rdata);
                        chk("err", 32'(rsp_err), 32'(cur.err));
                        if (cur.b2b) chk("accept_after_consume", cur.acc, last_cons + 1);
                        hold_left = cur.hold;
                    end
                    held_rd  = rsp_rdata;
                    held_err = rsp_err;
                end else begin
                    chk("rdata_stable", rsp_rdata, held_rd);
                    chk("err_stable", 32'(rsp_err), 32'(held_err));
                end
                if (hold_left == 0) begin
                    rsp_ready = 1'b1;
                    in_rsp    = 1'b0;
                    last_cons = cyc + 1;
                end else begin
                    rsp_ready = 1'b0;
                    hold_left--;
                end
            end else begin
                if (in_rsp) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_dropped: got rsp_valid=0 before rsp_ready, want 1 (cycle %0d)", cyc);
                    in_rsp = 1'b0;
                end
                rsp_ready = 1'b0;
                chk("idle_rdata", rsp_rdata, 32'd0);
                chk("idle_err", 32'(rsp_err), 32'd0);
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] erd, input logic eerr,
                         input int unsigned hold);
        int unsigned n = 0;
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, want 1", n);
            req_valid = 1'b0;
            return;
        end
        e.rdata = erd;
        e.err   = eerr;
        e.acc   = cyc + 1;
        e.hold  = hold;
        e.b2b   = (n_issued != 0);
        sb_q.push_back(e);
        n_issued++;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic txn4(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output int unsigned lat);
        int unsigned n = 0;
        r4_valid = 1'b1;
        r4_we    = we;
        r4_addr  = addr;
        r4_wdata = wdata;
        r4_be    = be;
        rd       = '0;
        lat      = 0;
        while (!req_ready4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready4) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept4_timeout: got req_ready=0 for %0d cycles, want 1", n);
            r4_valid = 1'b0;
            return;
        end
        @(negedge clk);
        r4_valid = 1'b0;
        lat = 1;
        while (!rsp_valid4 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata4;
        @(negedge clk);
    endtask

    initial begin
        int unsigned n;
        logic [31:0] rd;
        int unsigned lat;

        #1 rst_n = 1'b0;
        rst4_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        end
        rst_n  = 1'b1;
        rst4_n = 1'b1;
        #1 chk("release_req_ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        chk("release_req_ready4", 32'(req_ready4), 32'd1);

        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
        issue(1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0, 0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 5);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0);
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0);
        issue(1'b1, 32'h14, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 0);
        issue(1'b1, 32'h14, 32'h11223344, 4'h6, 32'h0, 1'b0, 0);
        issue(1'b1, 32'h14, 32'h99000000, 4'h8, 32'h0, 1'b0, 0);
        issue(1'b0, 32'h14, 32'h0, 4'h0, 32'h992233A5, 1'b0, 2);
        issue(1'b0, 32'h13, 32'h0, 4'h0, ERR_EN ? 32'h0 : 32'hDEADBEAA, ERR_EN, 0);
        issue(1'b1, 32'h00, 32'h0BADC0DE, 4'hF, 32'h0, 1'b0, 0);
        issue(1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, 32'h0, ERR_EN, 0);
        issue(1'b0, 32'h00, 32'h0, 4'h0, ERR_EN ? 32'h0BADC0DE : 32'hCAFEF00D, 1'b0, 0);
        issue(1'b1, 32'h11, 32'h00000000, 4'hF, 32'h0, ERR_EN, 0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, ERR_EN ? 32'hDEADBEAA : 32'h0, 1'b0, 0);
        issue(1'b0, 32'(8 * DEPTH), 32'h0, 4'h0, ERR_EN ? 32'h0 : 32'hCAFEF00D, ERR_EN, 1);

        n = 0;
        while ((sb_q.size() != 0 || in_rsp) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || in_rsp) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d responses outstanding, want 0", sb_q.size());
        end
        repeat (3) @(negedge clk);

        // Reset the LATENCY=4 instance while its store sits in WAIT.
        r4_valid = 1'b1;
        r4_we    = 1'b1;
        r4_addr  = 32'h20;
        r4_wdata = 32'h12345678;
        r4_be    = 4'hF;
        n = 0;
        while (!req_ready4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pre_wait_req_ready4", 32'(req_ready4), 32'd1);
        @(posedge clk);
        #1 r4_valid = 1'b0;
        r4_we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst4_n = 1'b0;
        #1 chk("midwait_rst_rsp_valid", 32'(rsp_valid4), 32'd0);
        chk("midwait_rst_req_ready", 32'(req_ready4), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("inrst_rsp_valid4", 32'(rsp_valid4), 32'd0);
            chk("inrst_rsp_rdata4", rsp_rdata4, 32'd0);
        end
        rst4_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready4", 32'(req_ready4), 32'd1);
        repeat (3) begin
            chk("post_rst_rsp_valid4", 32'(rsp_valid4), 32'd0);
            @(negedge clk);
        end

        txn4(1'b0, 32'h20, 32'h0, 4'h0, rd, lat);
        chk("committed_store_kept", rd, 32'h12345678);
        chk("latency4", lat, 32'(LAT4));
        chk("latency4_err", 32'(rsp_err4), 32'd0);
        txn4(1'b1, 32'h24, 32'h5555AAAA, 4'hF, rd, lat);
        chk("store4_rdata", rd, 32'd0);
        chk("store4_latency", lat, 32'(LAT4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, want end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
